// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the memory port arbiter: core requester, external
// loader/debug requester and the shared memory port. The arbiter takes the
// slave view; the requesters and the memory model take the master view.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    // core requester
    logic            c_req_i;
    logic            c_we_i;
    logic [XLEN-1:0] c_addr_i;
    logic [XLEN-1:0] c_wdata_i;
    logic            c_gnt_o;
    logic            c_rvalid_o;
    logic [XLEN-1:0] c_rdata_o;

    // external loader/debug requester
    logic            e_req_i;
    logic            e_we_i;
    logic [XLEN-1:0] e_addr_i;
    logic [XLEN-1:0] e_wdata_i;
    logic            e_lock_i;
    logic            e_gnt_o;
    logic            e_rvalid_o;
    logic [XLEN-1:0] e_rdata_o;

    // shared memory port (read data is combinational from m_addr_o)
    logic            m_we_o;
    logic [XLEN-1:0] m_addr_o;
    logic [XLEN-1:0] m_wdata_o;
    logic [XLEN-1:0] m_rdata_i;

    modport slave (
        input  c_req_i, c_we_i, c_addr_i, c_wdata_i,
        output c_gnt_o, c_rvalid_o, c_rdata_o,
        input  e_req_i, e_we_i, e_addr_i, e_wdata_i, e_lock_i,
        output e_gnt_o, e_rvalid_o, e_rdata_o,
        output m_we_o, m_addr_o, m_wdata_o,
        input  m_rdata_i
    );

    modport master (
        output c_req_i, c_we_i, c_addr_i, c_wdata_i,
        input  c_gnt_o, c_rvalid_o, c_rdata_o,
        output e_req_i, e_we_i, e_addr_i, e_wdata_i, e_lock_i,
        input  e_gnt_o, e_rvalid_o, e_rdata_o,
        input  m_we_o, m_addr_o, m_wdata_o,
        output m_rdata_i
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one unified instruction/data memory between the multicycle core and
// an external loader/debug port. One access per cycle, round-robin on ties,
// bounded burst lock for the external port, registered read return.
module mem_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_LOCK = 8      // 1..255
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    mem_port_arbiter_if.slave bus,
    output logic              lock_active_o
);

    typedef enum logic { ST_ARB, ST_EXT_LOCK } state_t;
    typedef enum logic { OWN_CORE, OWN_EXT } owner_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

    state_t          state;
    owner_t          last_owner;
    logic [7:0]      lock_cnt;
    logic            c_gnt;
    logic            e_gnt;
    logic            c_rvalid;
    logic            e_rvalid;
    logic [XLEN-1:0] c_rdata;
    logic [XLEN-1:0] e_rdata;

    // Grant decision: lock gives the external port exclusivity, otherwise a
    // lone requester wins and a tie goes to whoever was not served last.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        c_gnt = 1'b0;
        e_gnt = 1'b0;
        if (rstn_i) begin
            if (state == ST_EXT_LOCK) begin
                e_gnt = bus.e_req_i;
            end else if (bus.c_req_i && bus.e_req_i) begin
                c_gnt = (last_owner == OWN_EXT);
                e_gnt = (last_owner == OWN_CORE);
            end else begin
                c_gnt = bus.c_req_i;
                e_gnt = bus.e_req_i;
            end
        end
    end

    // Memory mux: the granted requester drives the port; idle cycles drive 0.
    always_comb begin
        bus.m_we_o    = 1'b0;
        bus.m_addr_o  = '0;
        bus.m_wdata_o = '0;
        if (c_gnt) begin
            bus.m_we_o    = bus.c_we_i;
            bus.m_addr_o  = bus.c_addr_i;
            bus.m_wdata_o = bus.c_wdata_i;
        end else if (e_gnt) begin
            bus.m_we_o    = bus.e_we_i;
            bus.m_addr_o  = bus.e_addr_i;
            bus.m_wdata_o = bus.e_wdata_i;
        end
    end

    // Arbitration FSM: round-robin owner tracking and the bounded external lock.
    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rstn_i) begin
            state      <= ST_ARB;
            last_owner <= OWN_EXT;
            lock_cnt   <= 8'd0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (c_gnt) last_owner <= OWN_CORE;
                    if (e_gnt) last_owner <= OWN_EXT;
                    if (e_gnt && bus.e_lock_i) begin
                        state    <= ST_EXT_LOCK;
                        lock_cnt <= 8'd1;
                    end
                end
                ST_EXT_LOCK: begin
                    if (!bus.e_lock_i || lock_cnt == MAX_CNT) begin
                        // Leaving with last_owner=EXT hands the next tie to the core.
                        state      <= ST_ARB;
                        lock_cnt   <= 8'd0;
                        last_owner <= OWN_EXT;
                    end else begin
                        lock_cnt <= lock_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= ST_ARB;
                    lock_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Read return: capture memory data for the winner of a read; rvalid is a
    // one-cycle strobe and rdata holds until that requester reads again.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            c_rvalid <= 1'b0;
            e_rvalid <= 1'b0;
            c_rdata  <= '0;
            e_rdata  <= '0;
        end else begin
            c_rvalid <= c_gnt && !bus.c_we_i;
            e_rvalid <= e_gnt && !bus.e_we_i;
            if (c_gnt && !bus.c_we_i) c_rdata <= bus.m_rdata_i;
            if (e_gnt && !bus.e_we_i) e_rdata <= bus.m_rdata_i;
        end
    end

    assign bus.c_gnt_o    = c_gnt;
    assign bus.e_gnt_o    = e_gnt;
    assign bus.c_rvalid_o = c_rvalid;
    assign bus.e_rvalid_o = e_rvalid;
    assign bus.c_rdata_o  = c_rdata;
    assign bus.e_rdata_o  = e_rdata;
    assign lock_active_o  = (state == ST_EXT_LOCK);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// lock/reset sequences, and a randomized run against a countdown-based model.
module tb_mem_port_arbiter;

    localparam int XLEN     = 32;
    localparam int MAX_LOCK = 8;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic lock_active;
    logic mem_ready = 1'b0;
    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];

    int total = 0;
    int bad   = 0;

    mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

    mem_port_arbiter #(.XLEN(XLEN), .MAX_LOCK(MAX_LOCK)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .bus           (bus),
        .lock_active_o (lock_active)
    );

    always #5 clk = ~clk;

    // Memory environment: combinational read, write on the rising edge.
    assign bus.m_rdata_i = mem[bus.m_addr_o[9:2]];

    // Preload on the first edge, then accept writes from the arbiter.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem[4]    <= 32'h0050_0093;
            mem[64]   <= 32'h1111_1111;
            mem[128]  <= 32'h2222_2222;
            mem_ready <= 1'b1;
        end else if (bus.m_we_o) begin
            mem[bus.m_addr_o[9:2]] <= bus.m_wdata_o;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                         input logic el);
        bus.c_req_i = cr; bus.c_we_i = cw; bus.c_addr_i = ca; bus.c_wdata_i = cd;
        bus.e_req_i = er; bus.e_we_i = ew; bus.e_addr_i = ea; bus.e_wdata_i = ed;
        bus.e_lock_i = el;
    endtask

    // Leaves time at posedge+1 of the first cycle out of reset.
    task automatic do_reset();
        @(posedge clk); #1;
        rstn = 1'b0;
        drive(L, L, 0, 0, L, L, 0, 0, L);
        @(posedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    typedef struct {
        logic        rstn;
        logic        c_req, c_we;
        logic [31:0] c_addr, c_wdata;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic        e_lock;
        logic        x_cg, x_eg, x_mwe;
        logic [31:0] x_maddr, x_mwdata;
        logic        x_crv;
        logic [31:0] x_crd;
        logic        x_erv;
        logic [31:0] x_erd;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // rstn | core req,we,addr,wdata | ext req,we,addr,wdata,lock | exp cg,eg,mwe,maddr,mwdata | crv,crd,erv,erd
        vecs[0]  = '{L, H,L,32'h10,0,  L,L,0,0,L,                    L,L,L,0,0,                  L,0,L,0};
        vecs[1]  = '{H, H,L,32'h10,0,  L,L,0,0,L,                    H,L,L,32'h10,0,             L,0,L,0};
        vecs[2]  = '{H, L,L,0,0,       L,L,0,0,L,                    L,L,L,0,0,                  H,32'h0050_0093,L,0};
        vecs[3]  = '{L, L,L,0,0,       L,L,0,0,L,                    L,L,L,0,0,                  L,32'h0050_0093,L,0};
        vecs[4]  = '{H, H,L,32'h100,0, H,L,32'h200,0,L,              H,L,L,32'h100,0,            L,0,L,0};
        vecs[5]  = '{H, H,L,32'h100,0, H,L,32'h200,0,L,              L,H,L,32'h200,0,            H,32'h1111_1111,L,0};
        vecs[6]  = '{H, H,L,32'h100,0, H,L,32'h200,0,L,              H,L,L,32'h100,0,            L,32'h1111_1111,H,32'h2222_2222};
        vecs[7]  = '{H, H,L,32'h100,0, H,L,32'h200,0,L,              L,H,L,32'h200,0,            H,32'h1111_1111,L,32'h2222_2222};
        vecs[8]  = '{H, L,L,0,0,       H,H,32'h40,32'hDEAD_BEEF,L,   L,H,H,32'h40,32'hDEAD_BEEF, L,32'h1111_1111,H,32'h2222_2222};
        vecs[9]  = '{H, H,L,32'h40,0,  L,L,0,0,L,                    H,L,L,32'h40,0,             L,32'h1111_1111,L,32'h2222_2222};
        vecs[10] = '{H, L,L,0,0,       L,L,0,0,L,                    L,L,L,0,0,                  H,32'hDEAD_BEEF,L,32'h2222_2222};

        drive(L, L, 0, 0, L, L, 0, 0, L);
        do_reset();

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 11; i++) begin
            rstn = vecs[i].rstn;
            drive(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata,
                  vecs[i].e_req, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_lock);
            @(negedge clk);
            check1($sformatf("v%0d c_gnt", i), bus.c_gnt_o, vecs[i].x_cg);
            check1($sformatf("v%0d e_gnt", i), bus.e_gnt_o, vecs[i].x_eg);
            check1($sformatf("v%0d m_we", i), bus.m_we_o, vecs[i].x_mwe);
            check($sformatf("v%0d m_addr", i), bus.m_addr_o, vecs[i].x_maddr);
            check($sformatf("v%0d m_wdata", i), bus.m_wdata_o, vecs[i].x_mwdata);
            check1($sformatf("v%0d c_rvalid", i), bus.c_rvalid_o, vecs[i].x_crv);
            check($sformatf("v%0d c_rdata", i), bus.c_rdata_o, vecs[i].x_crd);
            check1($sformatf("v%0d e_rvalid", i), bus.e_rvalid_o, vecs[i].x_erv);
            check($sformatf("v%0d e_rdata", i), bus.e_rdata_o, vecs[i].x_erd);
            check1($sformatf("v%0d lock_active", i), lock_active, L);
            @(posedge clk); #1;
        end

        // ---------------- full-length lock, forced yield ----------------
        begin
            int n_e = 0, n_lock = 0, wait_c = 0;
            logic got = 1'b0;
            do_reset();
            drive(H, L, 32'h100, 0, H, L, 32'h200, 0, H);
            @(negedge clk);
            check1("lockA first tie to core", bus.c_gnt_o, H);
            @(posedge clk); #1;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (bus.e_gnt_o) n_e++;
                if (lock_active) n_lock++;
                if (bus.c_gnt_o) begin
                    got = 1'b1;
                    break;
                end
                wait_c++;
                @(posedge clk); #1;
            end
            check1("lockA core granted in budget", got, H);
            check("lockA ext grants", n_e, MAX_LOCK + 1);
            check("lockA lock_active cycles", n_lock, MAX_LOCK);
            check("lockA core wait", wait_c, MAX_LOCK + 1);
        end

        // ---------------- lock released early ----------------
        do_reset();
        drive(L, L, 0, 0, H, L, 32'h200, 0, H);
        @(negedge clk);
        check1("lockB enter e_gnt", bus.e_gnt_o, H);
        @(posedge clk); #1;
        drive(H, L, 32'h100, 0, H, L, 32'h200, 0, H);
        for (int j = 1; j <= 3; j++) begin
            if (j == 3) bus.e_lock_i = L;
            @(negedge clk);
            check1($sformatf("lockB c%0d lock_active", j), lock_active, H);
            check1($sformatf("lockB c%0d c_gnt", j), bus.c_gnt_o, L);
            check1($sformatf("lockB c%0d e_gnt", j), bus.e_gnt_o, H);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check1("lockB exit c_gnt", bus.c_gnt_o, H);
        check1("lockB exit e_gnt", bus.e_gnt_o, L);
        check1("lockB exit lock_active", lock_active, L);
        @(posedge clk); #1;

        // ---------------- reset while locked with a read in flight ----------------
        do_reset();
        drive(L, L, 0, 0, H, L, 32'h200, 0, H);
        @(negedge clk);
        check1("rstC enter e_gnt", bus.e_gnt_o, H);
        @(posedge clk); #1;
        rstn = 1'b0;
        drive(H, L, 32'h100, 0, H, L, 32'h200, 0, H);
        @(negedge clk);
        check1("rstC in-reset c_gnt", bus.c_gnt_o, L);
        check1("rstC in-reset e_gnt", bus.e_gnt_o, L);
        check("rstC in-reset m_addr", bus.m_addr_o, 0);
        check1("rstC e_rvalid before edge", bus.e_rvalid_o, H);
        check1("rstC lock_active before edge", lock_active, H);
        @(posedge clk); #1;
        @(negedge clk);
        check1("rstC lock_active after edge", lock_active, L);
        check1("rstC e_rvalid after edge", bus.e_rvalid_o, L);
        check1("rstC c_gnt after edge", bus.c_gnt_o, L);
        check1("rstC e_gnt after edge", bus.e_gnt_o, L);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check1("rstC first tie core", bus.c_gnt_o, H);
        check1("rstC first tie ext", bus.e_gnt_o, L);
        @(posedge clk); #1;

        // ---------------- randomized run against reference model ----------------
        begin
            logic c_pend = 1'b0, e_pend = 1'b0;
            logic c_we = 1'b0, e_we = 1'b0, e_lock = 1'b0;
            logic [31:0] c_addr = 0, c_wdata = 0, e_addr = 0, e_wdata = 0;
            logic prefer_core = 1'b1;      // next tie goes to the core
            int   locked_left = 0;         // remaining exclusive cycles for ext
            logic m_crv = 1'b0, m_erv = 1'b0;
            logic [31:0] m_crd = 0, m_erd = 0;
            logic xc, xe, xwe;
            logic [31:0] xaddr, xwdata;
            int c_wait = 0, max_wait = 0;

            do_reset();
            ref_mem = mem;
            for (int cyc = 0; cyc < 600; cyc++) begin
                if (!c_pend && $urandom_range(0, 2) != 0) begin
                    c_pend  = 1'b1;
                    c_we    = 1'($urandom_range(0, 1));
                    c_addr  = 32'($urandom_range(0, 15)) << 2;
                    c_wdata = $urandom;
                end
                if (!e_pend && $urandom_range(0, 2) != 0) begin
                    e_pend  = 1'b1;
                    e_we    = 1'($urandom_range(0, 1));
                    e_addr  = 32'($urandom_range(0, 15)) << 2;
                    e_wdata = $urandom;
                end
                e_lock = ($urandom_range(0, 3) != 0);
                drive(c_pend, c_we, c_addr, c_wdata, e_pend, e_we, e_addr, e_wdata, e_lock);
                @(negedge clk);

                if (locked_left > 0) begin
                    xc = 1'b0;
                    xe = e_pend;
                end else if (c_pend && e_pend) begin
                    xc = prefer_core;
                    xe = !prefer_core;
                end else begin
                    xc = c_pend;
                    xe = e_pend;
                end
                xwe    = xc ? c_we    : (xe ? e_we    : 1'b0);
                xaddr  = xc ? c_addr  : (xe ? e_addr  : 32'd0);
                xwdata = xc ? c_wdata : (xe ? e_wdata : 32'd0);

                check1($sformatf("rnd%0d c_gnt", cyc), bus.c_gnt_o, xc);
                check1($sformatf("rnd%0d e_gnt", cyc), bus.e_gnt_o, xe);
                check1($sformatf("rnd%0d m_we", cyc), bus.m_we_o, xwe);
                check($sformatf("rnd%0d m_addr", cyc), bus.m_addr_o, xaddr);
                check($sformatf("rnd%0d m_wdata", cyc), bus.m_wdata_o, xwdata);
                check1($sformatf("rnd%0d c_rvalid", cyc), bus.c_rvalid_o, m_crv);
                check($sformatf("rnd%0d c_rdata", cyc), bus.c_rdata_o, m_crd);
                check1($sformatf("rnd%0d e_rvalid", cyc), bus.e_rvalid_o, m_erv);
                check($sformatf("rnd%0d e_rdata", cyc), bus.e_rdata_o, m_erd);
                check1($sformatf("rnd%0d lock_active", cyc), lock_active, locked_left > 0);

                if (c_pend) begin
                    if (bus.c_gnt_o) begin
                        if (c_wait > max_wait) max_wait = c_wait;
                        c_wait = 0;
                    end else begin
                        c_wait++;
                    end
                end

                m_crv = xc && !c_we;
                m_erv = xe && !e_we;
                if (xc && !c_we) m_crd = ref_mem[c_addr[9:2]];
                if (xe && !e_we) m_erd = ref_mem[e_addr[9:2]];
                if (xc && c_we) ref_mem[c_addr[9:2]] = c_wdata;
                if (xe && e_we) ref_mem[e_addr[9:2]] = e_wdata;
                if (xc) prefer_core = 1'b0;
                if (xe) prefer_core = 1'b1;
                if (locked_left > 0) begin
                    locked_left--;
                    if (!e_lock) locked_left = 0;
                end else if (xe && e_lock) begin
                    locked_left = MAX_LOCK;
                end
                if (xc) c_pend = 1'b0;
                if (xe) e_pend = 1'b0;
                @(posedge clk); #1;
            end
            check1("rnd starvation bound", max_wait <= MAX_LOCK + 1, H);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
